hand_reader: RTL and testbench
==============================

// Module: hand_reader
// PURPOSE
//  Consumer end of the deal interface. Latches both 24-bit dealt hands on the dealer's done pulse.
//  Optionally sorts each hand, then streams the non-empty cards one per beat over a valid/ready port
//  to game/play logic, followed by per-hand card counts. Sits between the deal FSM and the turn logic.
// PARAMETERS
//  CARD_W      6   bits per card code; code 0 = empty slot
//  HAND_CARDS  4   slots per hand; hand bus width = CARD_W*HAND_CARDS
// PORTS
//  clka          in   1   single clock, all flops on posedge
//  restart_n     in   1   asynchronous active-low reset
//  player_cards  in   24  dealt player hand, slot k = [6k+5:6k]
//  comp_cards    in   24  dealt computer hand, same packing
//  done          in   1   deal-complete level from dealer; a rising edge triggers capture
//  card_data     out  6   streamed card code
//  card_owner    out  1   0 = player, 1 = computer
//  card_slot     out  2   slot index after optional sort
//  card_valid    out  1   beat valid
//  card_ready    in   1   downstream accept
//  card_last     out  1   high with the final beat
//  busy          out  1   high in CAPTURE/SORT/STREAM
//  player_count  out  3   non-empty player cards, 0..4
//  comp_count    out  3   non-empty computer cards, 0..4
//  counts_valid  out  1   one-cycle pulse in DONE
//  overrun       out  1   sticky: done rose while busy; cleared on next capture
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, hand regs 0, done_q 0.
//  Edge detect: done_q <= done; rise = done & ~done_q. The block never samples the hand buses except on rise in IDLE.
//  IDLE -> CAPTURE on rise. In CAPTURE, both hands are registered, counts cleared, overrun cleared.
//  CAPTURE -> SORT (SORT_EN) or STREAM. CAPTURE lasts 1 cycle.
//  STREAM: slot scan runs player 0..3, then comp 0..3. Zero codes are skipped with no bubble cycle:
//   the next non-zero card is found combinationally from the scan pointer.
//   Without SORT_EN, the first card_valid is asserted 2 cycles after the done rise is sampled.
//   card_data/owner/slot/last hold stable while valid && !ready. A beat completes on valid && ready.
//   Each completed beat increments the matching count (3-bit, max 4, no wrap possible).
//   card_last = no non-zero card remains after the current one.
//   After the last handshake -> DONE. If all 8 slots are zero -> DONE directly, with no beats and counts 0.
//  DONE: counts_valid = 1 for 1 cycle. Counts hold until the next CAPTURE. -> IDLE.
//  A done rise while busy or in DONE is ignored for capture and sets overrun.
//  Async reset mid-stream aborts the stream; a partially consumed hand is discarded.
//  A done level held high after capture does not retrigger; it needs a low-then-high.
// CONFIGURATION
//  SORT_EN defined: SORT state runs 4 cycles of odd-even transposition on both hands in parallel.
//   Even phase swaps (0,1),(2,3); odd phase swaps (1,2). Phase order even, odd, even, odd.
//   Hands end ascending by unsigned code, so zero slots sort to the low indices and are skipped.
//   First card_valid is asserted 6 cycles after the rise is sampled.
//  SORT_EN undefined: the SORT state and its logic are absent, and cards stream in dealt slot order.
// STRUCTURE
//  Shared package (card_pkg): CARD_W, HAND_CARDS, CARD_EMPTY = 6'b000000, OWNER_PLAYER/OWNER_COMP,
//   state encoding IDLE/CAPTURE/SORT/STREAM/DONE (3 bits).
//  Sub-module hand_sorter (SORT_EN only): one 4-slot compare-swap stage selected by phase bit,
//   instantiated twice (player, comp).
// TESTING
//  1 Hands P = {0,0x18,0x0C,0} (slot3..0), C = {0x33,0x06,0x2A,0x35}, done rise, ready=1, no SORT_EN ->
//    6 beats: P1 0x0C, P2 0x18, C0 0x35, C1 0x2A, C2 0x06, C3 0x33 (last); counts 2/4; counts_valid pulse.
//  2 Same hands with SORT_EN -> player 0x0C,0x18 then comp 0x06,0x2A,0x33,0x35; first valid 6 cycles after rise.
//  3 ready toggled 1/0 every cycle -> card_data/slot/owner stable while stalled; no beat lost or duplicated.
//  4 All slots zero, done rise -> no card_valid, counts 0/0, counts_valid one cycle after CAPTURE.
//  5 Second done rise mid-stream -> overrun=1, stream unchanged; next capture clears overrun.
//  6 restart_n low during STREAM beat 3 -> all outputs 0 immediately; after release, a fresh done rise streams the full hand again.

Source files
------------

// File: rtl/card_pkg.sv
// card_pkg: shared card/hand definitions for the deal consumer path.
// Card code 0 marks an empty slot; hands pack slot k at [CARD_W*k +: CARD_W].
package card_pkg;

    localparam int CARD_W     = 6;
    localparam int HAND_CARDS = 4;
    localparam int HAND_W     = CARD_W * HAND_CARDS;

    localparam logic [CARD_W-1:0] CARD_EMPTY   = 6'b000000;
    localparam logic              OWNER_PLAYER = 1'b0;
    localparam logic              OWNER_COMP   = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SORT    = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Compare-swap of two adjacent slots; returns {upper_slot, lower_slot}
    // so the lower slot always ends with the smaller unsigned code.
    function automatic logic [2*CARD_W-1:0] order_pair(
        input logic [CARD_W-1:0] lower_in,
        input logic [CARD_W-1:0] upper_in
    );
        if (lower_in > upper_in)
            order_pair = {lower_in, upper_in};
        else
            order_pair = {upper_in, lower_in};
    endfunction

endpackage

// File: rtl/hand_sorter.sv
// hand_sorter: one odd-even transposition stage over a 4-slot hand.
// phase 0 orders slot pairs (0,1),(2,3); phase 1 orders (1,2).
// Used by hand_reader only when SORT_EN is defined.
module hand_sorter
    import card_pkg::*;
(
    input  logic [HAND_W-1:0] hand_in,
    input  logic              phase,
    output logic [HAND_W-1:0] hand_out
);

    // Single compare-swap stage selected by the phase bit
    always_comb begin
        hand_out = hand_in;
        if (!phase) begin
            hand_out[0*CARD_W +: 2*CARD_W] = order_pair(hand_in[0*CARD_W +: CARD_W],
                                                        hand_in[1*CARD_W +: CARD_W]);
            hand_out[2*CARD_W +: 2*CARD_W] = order_pair(hand_in[2*CARD_W +: CARD_W],
                                                        hand_in[3*CARD_W +: CARD_W]);
        end else begin
            hand_out[1*CARD_W +: 2*CARD_W] = order_pair(hand_in[1*CARD_W +: CARD_W],
                                                        hand_in[2*CARD_W +: CARD_W]);
        end
    end

endmodule

// File: rtl/hand_reader.sv
// hand_reader: latches both dealt hands on a rising edge of done, optionally
// sorts them, then streams non-empty cards (player slots 0..3, then computer
// slots 0..3) over a valid/ready port, followed by a one-cycle counts pulse.
// Build option: define SORT_EN to sort each hand ascending before streaming.
module hand_reader
    import card_pkg::*;
(
    input  logic              clka,
    input  logic              restart_n,
    input  logic [HAND_W-1:0] player_cards,
    input  logic [HAND_W-1:0] comp_cards,
    input  logic              done,
    output logic [CARD_W-1:0] card_data,
    output logic              card_owner,
    output logic [1:0]        card_slot,
    output logic              card_valid,
    input  logic              card_ready,
    output logic              card_last,
    output logic              busy,
    output logic [2:0]        player_count,
    output logic [2:0]        comp_count,
    output logic              counts_valid,
    output logic              overrun
);

    state_t             state_reg, state_next;
    logic               done_q;
    logic               rise;
    logic [HAND_W-1:0]  player_hand_reg, comp_hand_reg;
    logic [3:0]         ptr_reg;
    logic [CARD_W-1:0]  card_data_reg;
    logic               card_owner_reg, card_valid_reg, card_last_reg;
    logic [1:0]         card_slot_reg;
    logic [2:0]         player_count_reg, comp_count_reg;
    logic               overrun_reg;
    logic               hands_empty;

    // Flattened scan view: index 0..3 player slots, 4..7 computer slots
    logic [CARD_W-1:0]  slot_code [2*HAND_CARDS];
    logic               found;
    logic [2:0]         found_idx;
    logic               more_after;

    assign rise        = done & ~done_q;
    assign hands_empty = (player_hand_reg == '0) && (comp_hand_reg == '0);

    for (genvar gi = 0; gi < HAND_CARDS; gi++) begin : g_unpack
        assign slot_code[gi]              = player_hand_reg[gi*CARD_W +: CARD_W];
        assign slot_code[gi + HAND_CARDS] = comp_hand_reg[gi*CARD_W +: CARD_W];
    end

`ifdef SORT_EN
    logic [1:0]        sort_cnt_reg;
    logic [HAND_W-1:0] player_sorted, comp_sorted;

    hand_sorter u_sort_player (
        .hand_in  (player_hand_reg),
        .phase    (sort_cnt_reg[0]),
        .hand_out (player_sorted)
    );

    hand_sorter u_sort_comp (
        .hand_in  (comp_hand_reg),
        .phase    (sort_cnt_reg[0]),
        .hand_out (comp_sorted)
    );
`endif

    // Find the next non-empty slot at or after the scan pointer, and whether any follow it
    always_comb begin
        found      = 1'b0;
        found_idx  = 3'd0;
        more_after = 1'b0;
        for (int i = 0; i < 2*HAND_CARDS; i++) begin
            if (!found && (4'(i) >= ptr_reg) && (slot_code[i] != CARD_EMPTY)) begin
                found     = 1'b1;
                found_idx = 3'(i);
            end else if (found && (slot_code[i] != CARD_EMPTY)) begin
                more_after = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rise)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                if (hands_empty)
                    state_next = DONE;
                else
`ifdef SORT_EN
                    state_next = SORT;
`else
                    state_next = STREAM;
`endif
            end
`ifdef SORT_EN
            SORT: begin
                if (sort_cnt_reg == 2'd3)
                    state_next = STREAM;
            end
`endif
            STREAM: begin
                if (card_valid_reg && card_ready && card_last_reg)
                    state_next = DONE;
                else if (!card_valid_reg && !found)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture, sort, beat generation, counts and overrun tracking
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            done_q           <= 1'b0;
            player_hand_reg  <= '0;
            comp_hand_reg    <= '0;
            ptr_reg          <= '0;
            card_data_reg    <= '0;
            card_owner_reg   <= 1'b0;
            card_slot_reg    <= '0;
            card_valid_reg   <= 1'b0;
            card_last_reg    <= 1'b0;
            player_count_reg <= '0;
            comp_count_reg   <= '0;
            overrun_reg      <= 1'b0;
`ifdef SORT_EN
            sort_cnt_reg     <= '0;
`endif
        end else begin
            done_q <= done;

            // Hand buses are only sampled on a rise seen in IDLE
            if (state_reg == IDLE && rise) begin
                player_hand_reg <= player_cards;
                comp_hand_reg   <= comp_cards;
            end

            if (rise && state_reg != IDLE)
                overrun_reg <= 1'b1;
            else if (state_reg == CAPTURE)
                overrun_reg <= 1'b0;

            if (state_reg == CAPTURE) begin
                player_count_reg <= '0;
                comp_count_reg   <= '0;
                ptr_reg          <= '0;
                card_valid_reg   <= 1'b0;
                card_last_reg    <= 1'b0;
`ifdef SORT_EN
                sort_cnt_reg     <= '0;
`endif
            end

`ifdef SORT_EN
            if (state_reg == SORT) begin
                player_hand_reg <= player_sorted;
                comp_hand_reg   <= comp_sorted;
                sort_cnt_reg    <= sort_cnt_reg + 2'd1;
            end
`endif

            if (state_reg == STREAM) begin
                if (card_valid_reg && card_ready) begin
                    if (card_owner_reg == OWNER_PLAYER)
                        player_count_reg <= player_count_reg + 3'd1;
                    else
                        comp_count_reg <= comp_count_reg + 3'd1;
                end
                // Output beat only advances when empty or accepted, so it holds while stalled
                if (!card_valid_reg || card_ready) begin
                    if (found) begin
                        card_valid_reg <= 1'b1;
                        card_data_reg  <= slot_code[found_idx];
                        card_owner_reg <= found_idx[2];
                        card_slot_reg  <= found_idx[1:0];
                        card_last_reg  <= ~more_after;
                        ptr_reg        <= {1'b0, found_idx} + 4'd1;
                    end else begin
                        card_valid_reg <= 1'b0;
                        card_last_reg  <= 1'b0;
                    end
                end
            end
        end
    end

    assign card_data    = card_data_reg;
    assign card_owner   = card_owner_reg;
    assign card_slot    = card_slot_reg;
    assign card_valid   = card_valid_reg;
    assign card_last    = card_last_reg;
    assign player_count = player_count_reg;
    assign comp_count   = comp_count_reg;
    assign overrun      = overrun_reg;
    assign busy         = (state_reg == CAPTURE) || (state_reg == SORT) || (state_reg == STREAM);
    assign counts_valid = (state_reg == DONE);

endmodule

// File: tb/tb_hand_reader.sv
// tb_hand_reader: table-driven directed bench for hand_reader, plus
// hand-written sequences for stall, overrun and mid-stream reset.
// Expected beat order follows the SORT_EN build option when it is defined.
module tb_hand_reader;
    import card_pkg::*;

`ifdef SORT_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic              clka = 1'b0;
    logic              restart_n;
    logic [HAND_W-1:0] player_cards, comp_cards;
    logic              done, card_ready;
    logic [CARD_W-1:0] card_data;
    logic              card_owner, card_valid, card_last, busy, counts_valid, overrun;
    logic [1:0]        card_slot;
    logic [2:0]        player_count, comp_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [HAND_W-1:0] player;
        logic [HAND_W-1:0] comp;
        int                n;
        logic [71:0]       beats;   // beat j = {owner, slot[1:0], data[5:0]} at [9j +: 9]
        logic [2:0]        pc;
        logic [2:0]        cc;
    } vec_t;

    vec_t vecs [4];

    hand_reader dut (
        .clka         (clka),
        .restart_n    (restart_n),
        .player_cards (player_cards),
        .comp_cards   (comp_cards),
        .done         (done),
        .card_data    (card_data),
        .card_owner   (card_owner),
        .card_slot    (card_slot),
        .card_valid   (card_valid),
        .card_ready   (card_ready),
        .card_last    (card_last),
        .busy         (busy),
        .player_count (player_count),
        .comp_count   (comp_count),
        .counts_valid (counts_valid),
        .overrun      (overrun)
    );

    always #5 clka = ~clka;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int ci, input logic own, input logic [1:0] slot, input logic [5:0] data);
        vecs[ci].beats[vecs[ci].n*9 +: 9] = {own, slot, data};
        vecs[ci].n++;
    endtask

    // One transaction: done rise, stream with optional ready toggling, optional
    // second done rise mid-stream; checks every beat, latency, counts and overrun.
    task automatic run_case(input int ci, input bit toggle, input bit inject);
        int         k, beats, pulses;
        bit         first_seen, prev_stall, fin;
        logic [9:0] held;
        logic [9:0] got;
        logic [9:0] want;
        player_cards = vecs[ci].player;
        comp_cards   = vecs[ci].comp;
        done = 1'b0;
        card_ready = 1'b0;
        @(negedge clka);
        done = 1'b1;
        @(posedge clka);
        k = 0; beats = 0; pulses = 0;
        first_seen = 0; prev_stall = 0; fin = 0; held = '0;
        while (!fin && k < 80) begin
            @(negedge clka);
            if (inject && k == 3) done = 1'b0;
            if (inject && k == 4) done = 1'b1;
            card_ready = toggle ? (k % 2 == 1) : 1'b1;
            if (k == 2) check("overrun_clear", overrun, 0);
            got = {card_owner, card_slot, card_data, card_last};
            if (prev_stall) check("stall_hold", {card_valid, got}, {1'b1, held});
            if (card_valid && !first_seen) begin
                first_seen = 1;
                check("first_valid_latency", k, LAT);
            end
            if (card_valid && card_ready) begin
                if (beats < vecs[ci].n) begin
                    want = {vecs[ci].beats[beats*9 +: 9], beats == vecs[ci].n - 1};
                    check("beat", got, want);
                end else begin
                    check("extra_beat", beats, vecs[ci].n);
                end
                $display("case %0d beat %0d: owner=%0d slot=%0d data=0x%02h last=%0d",
                         ci, beats, card_owner, card_slot, card_data, card_last);
                beats++;
            end
            prev_stall = card_valid && !card_ready;
            held = got;
            if (counts_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("counts", {player_count, comp_count}, {vecs[ci].pc, vecs[ci].cc});
                    if (vecs[ci].n == 0) check("empty_cv_latency", k, 1);
                end
            end
            if (pulses > 0 && !counts_valid) fin = 1;
            k++;
        end
        if (!fin) check("timeout", 0, 1);
        check("beat_count", beats, vecs[ci].n);
        check("cv_pulse_width", pulses, 1);
        check("overrun_end", overrun, inject);
        check("counts_hold", {player_count, comp_count}, {vecs[ci].pc, vecs[ci].cc});
        check("busy_after", busy, 0);
        repeat (3) @(negedge clka);
        check("no_retrigger", {busy, card_valid}, 0);
        $display("case %0d toggle=%0d inject=%0d: beats=%0d counts=%0d/%0d overrun=%0d",
                 ci, toggle, inject, beats, player_count, comp_count, overrun);
        done = 1'b0;
        card_ready = 1'b0;
        @(negedge clka);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            vecs[i].n = 0;
            vecs[i].beats = '0;
        end
        // 0: mixed hands from the reference deal
        vecs[0].player = {6'h00, 6'h18, 6'h0C, 6'h00};
        vecs[0].comp   = {6'h33, 6'h06, 6'h2A, 6'h35};
        vecs[0].pc = 3'd2; vecs[0].cc = 3'd4;
`ifdef SORT_EN
        add(0, 0, 2'd2, 6'h0C); add(0, 0, 2'd3, 6'h18);
        add(0, 1, 2'd0, 6'h06); add(0, 1, 2'd1, 6'h2A);
        add(0, 1, 2'd2, 6'h33); add(0, 1, 2'd3, 6'h35);
`else
        add(0, 0, 2'd1, 6'h0C); add(0, 0, 2'd2, 6'h18);
        add(0, 1, 2'd0, 6'h35); add(0, 1, 2'd1, 6'h2A);
        add(0, 1, 2'd2, 6'h06); add(0, 1, 2'd3, 6'h33);
`endif
        // 1: all slots empty
        vecs[1].player = '0;
        vecs[1].comp   = '0;
        vecs[1].pc = 3'd0; vecs[1].cc = 3'd0;
        // 2: full player hand in descending slot order, empty computer hand
        vecs[2].player = {6'h01, 6'h02, 6'h03, 6'h04};
        vecs[2].comp   = '0;
        vecs[2].pc = 3'd4; vecs[2].cc = 3'd0;
`ifdef SORT_EN
        add(2, 0, 2'd0, 6'h01); add(2, 0, 2'd1, 6'h02);
        add(2, 0, 2'd2, 6'h03); add(2, 0, 2'd3, 6'h04);
`else
        add(2, 0, 2'd0, 6'h04); add(2, 0, 2'd1, 6'h03);
        add(2, 0, 2'd2, 6'h02); add(2, 0, 2'd3, 6'h01);
`endif
        // 3: single card in the very last slot
        vecs[3].player = '0;
        vecs[3].comp   = {6'h3F, 18'h0};
        vecs[3].pc = 3'd0; vecs[3].cc = 3'd1;
        add(3, 1, 2'd3, 6'h3F);

        restart_n = 1'b0;
        done = 1'b0;
        card_ready = 1'b0;
        player_cards = '0;
        comp_cards = '0;
        repeat (3) @(negedge clka);
        check("reset_state",
              {card_valid, card_last, busy, counts_valid, overrun, card_owner,
               card_slot, card_data, player_count, comp_count}, 0);
        restart_n = 1'b1;
        @(negedge clka);

        for (int ci = 0; ci < 4; ci++) run_case(ci, 0, 0);
        run_case(0, 1, 0);
        run_case(2, 1, 0);
        run_case(0, 0, 1);
        run_case(3, 0, 0);

        // Reset while the third beat of the reference deal is on the port
        player_cards = vecs[0].player;
        comp_cards   = vecs[0].comp;
        card_ready = 1'b1;
        @(negedge clka);
        done = 1'b1;
        @(posedge clka);
        repeat (LAT + 3) @(negedge clka);
        check("pre_reset_valid", card_valid, 1);
        restart_n = 1'b0;
        done = 1'b0;
        #1;
        check("midstream_reset",
              {card_valid, card_last, busy, counts_valid, overrun, card_owner,
               card_slot, card_data, player_count, comp_count}, 0);
        $display("mid-stream reset: valid=%0d busy=%0d counts=%0d/%0d",
                 card_valid, busy, player_count, comp_count);
        @(negedge clka);
        restart_n = 1'b1;
        repeat (2) @(negedge clka);
        check("post_reset_idle", {busy, card_valid}, 0);
        run_case(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
